// File: rtl/trigger_chain_reader.sv
// Host-side reader for the daisy-chained trigger timers: clocks the chain, assembles
// 32-bit words LSB-first, hands them out over valid/ready, then re-arms the timers.
module trigger_chain_reader #(
  parameter int NUM_TIMERS   = 2,
  parameter int HALF_PERIOD  = 8,
  parameter int REARM_CYCLES = 4,
  parameter int IDX_W        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             tmr_data_clock,
  output logic             tmr_shiftin,
  input  logic             tmr_shiftout,
  output logic             tmr_reset_n,
  output logic [31:0]      word_data,
  output logic [IDX_W-1:0] word_index,
  output logic             word_valid,
  input  logic             word_ready
);

  localparam int PH_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int RA_W = (REARM_CYCLES > 1) ? $clog2(REARM_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_WORD_OUT,
    S_REARM
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              sync_meta;
  logic              sync_data;
  logic [PH_W-1:0]   phase_cnt;
  logic [4:0]        bit_cnt;
  logic [IDX_W-1:0]  word_cnt;
  logic [RA_W-1:0]   rearm_cnt;
  logic [31:0]       sr;
  logic              done_q;
  logic              data_clock_q;
  logic              reset_n_q;

  logic phase_end;
  logic last_bit;
  logic last_word;
  logic rearm_end;

  assign phase_end = (phase_cnt == PH_W'(HALF_PERIOD - 1));
  assign last_bit  = (bit_cnt == 5'd31);
  assign last_word = (word_cnt == IDX_W'(NUM_TIMERS - 1));
  assign rearm_end = (rearm_cnt == RA_W'(REARM_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start arriving in the done cycle is dropped, so a new read can never overlap the pulse.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start && !done_q) begin
          next_state = S_LOW;
        end
      end
      S_LOW: begin
        if (phase_end) begin
          next_state = last_bit ? S_WORD_OUT : S_HIGH;
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          next_state = S_LOW;
        end
      end
      S_WORD_OUT: begin
        if (word_ready) begin
          next_state = last_word ? S_REARM : S_HIGH;
        end
      end
      S_REARM: begin
        if (rearm_end) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_meta    <= 1'b0;
      sync_data    <= 1'b0;
      phase_cnt    <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      rearm_cnt    <= '0;
      sr           <= '0;
      done_q       <= 1'b0;
      data_clock_q <= 1'b0;
      reset_n_q    <= 1'b0;
    end else begin
      sync_meta <= tmr_shiftout;
      sync_data <= sync_meta;

      if ((next_state != state) || ((state != S_LOW) && (state != S_HIGH))) begin
        phase_cnt <= '0;
      end else begin
        phase_cnt <= phase_cnt + PH_W'(1);
      end

      if (state == S_REARM) begin
        rearm_cnt <= rearm_cnt + RA_W'(1);
      end else begin
        rearm_cnt <= '0;
      end

      case (state)
        S_IDLE: begin
          if (start && !done_q) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            sr       <= '0;
          end
        end
        S_LOW: begin
          // Sample only at the very end of the low phase, long after the timers have settled.
          if (phase_end) begin
            sr      <= {sync_data, sr[31:1]};
            bit_cnt <= bit_cnt + 5'd1;
          end
        end
        S_WORD_OUT: begin
          if (word_ready) begin
            word_cnt <= word_cnt + IDX_W'(1);
          end
        end
        default: ;
      endcase

      done_q       <= (state == S_REARM) && rearm_end;
      data_clock_q <= (next_state == S_HIGH);
      reset_n_q    <= (next_state != S_REARM);
    end
  end

  always_comb begin
    busy           = (state != S_IDLE);
    done           = done_q;
    tmr_data_clock = data_clock_q;
    tmr_shiftin    = 1'b0;
    tmr_reset_n    = reset_n_q;
    word_data      = sr;
    word_index     = word_cnt;
    word_valid     = (state == S_WORD_OUT);
  end

endmodule

// File: tb/tb_trigger_chain_reader.sv
// Directed bench for trigger_chain_reader: a two-timer chain (A) and a single-timer chain (B),
// each driven by a small behavioural timer model that reloads its latched value while reset_n is low.
module tb_trigger_chain_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        rst_a, start_a, busy_a, done_a, dclk_a, shiftin_a, shiftout_a, reset_n_a, valid_a, ready_a;
  logic [31:0] data_a;
  logic [0:0]  index_a;

  logic        rst_b, start_b, busy_b, done_b, dclk_b, shiftin_b, shiftout_b, reset_n_b, valid_b, ready_b;
  logic [31:0] data_b;
  logic [0:0]  index_b;

  trigger_chain_reader #(
    .NUM_TIMERS(2), .HALF_PERIOD(8), .REARM_CYCLES(4), .IDX_W(1)
  ) dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .tmr_data_clock(dclk_a), .tmr_shiftin(shiftin_a), .tmr_shiftout(shiftout_a),
    .tmr_reset_n(reset_n_a), .word_data(data_a), .word_index(index_a),
    .word_valid(valid_a), .word_ready(ready_a)
  );

  trigger_chain_reader #(
    .NUM_TIMERS(1), .HALF_PERIOD(6), .REARM_CYCLES(4), .IDX_W(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .tmr_data_clock(dclk_b), .tmr_shiftin(shiftin_b), .tmr_shiftout(shiftout_b),
    .tmr_reset_n(reset_n_b), .word_data(data_b), .word_index(index_b),
    .word_valid(valid_b), .word_ready(ready_b)
  );

  // Timer chain A: shiftin -> far -> near -> shiftout; noise replaces shiftout only while data_clock is high.
  logic [31:0] near_a = '0, far_a = '0, latch_near = '0, latch_far = '0;
  logic        prev_dclk_a = 1'b0, noise = 1'b0, noise_en = 1'b0;

  always @(posedge clk) begin
    prev_dclk_a <= dclk_a;
    noise       <= 1'($urandom);
    if (!reset_n_a) begin
      near_a <= latch_near;
      far_a  <= latch_far;
    end else if (dclk_a && !prev_dclk_a) begin
      near_a <= {far_a[0], near_a[31:1]};
      far_a  <= {shiftin_a, far_a[31:1]};
    end
  end
  assign shiftout_a = (noise_en && dclk_a) ? noise : near_a[0];

  logic [31:0] timer_b = '0, latch_b = '0;
  logic        prev_dclk_b = 1'b0;

  always @(posedge clk) begin
    prev_dclk_b <= dclk_b;
    if (!reset_n_b) begin
      timer_b <= latch_b;
    end else if (dclk_b && !prev_dclk_b) begin
      timer_b <= {shiftin_b, timer_b[31:1]};
    end
  end
  assign shiftout_b = timer_b[0];

  // Monitors: handshaken words, data_clock rises, cycles with tmr_reset_n low, done pulses.
  int          nwords_a = 0, rises_a = 0, rearm_low_a = 0, dones_a = 0;
  logic        clr_a = 1'b0;
  logic [31:0] words_a [8];
  logic [0:0]  idxs_a [8];

  always @(posedge clk) begin
    if (clr_a) begin
      nwords_a <= 0; rises_a <= 0; rearm_low_a <= 0; dones_a <= 0;
    end else begin
      if (valid_a && ready_a && nwords_a < 8) begin
        words_a[nwords_a] <= data_a;
        idxs_a[nwords_a]  <= index_a;
        nwords_a          <= nwords_a + 1;
      end
      if (dclk_a && !prev_dclk_a) rises_a <= rises_a + 1;
      if (!reset_n_a) rearm_low_a <= rearm_low_a + 1;
      if (done_a) dones_a <= dones_a + 1;
    end
  end

  int          nwords_b = 0, rises_b = 0;
  logic        clr_b = 1'b0;
  logic [31:0] words_b [8];
  logic [0:0]  idxs_b [8];

  always @(posedge clk) begin
    if (clr_b) begin
      nwords_b <= 0; rises_b <= 0;
    end else begin
      if (valid_b && ready_b && nwords_b < 8) begin
        words_b[nwords_b] <= data_b;
        idxs_b[nwords_b]  <= index_b;
        nwords_b          <= nwords_b + 1;
      end
      if (dclk_b && !prev_dclk_b) rises_b <= rises_b + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_a();
    clr_a = 1'b1;
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  task automatic clear_b();
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
  endtask

  // cyc counts negedges since the edge that accepted start (1 on entry right after pulse_start).
  task automatic wait_done_a(input string tag, input int limit, output int cyc);
    cyc = 1;
    while (!done_a && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done_a), 32'd1);
  endtask

  task automatic wait_done_b(input string tag, input int limit, output int cyc);
    cyc = 1;
    while (!done_b && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done_seen"}, 32'(done_b), 32'd1);
  endtask

  task automatic wait_rises_a(input string tag, input int n, input int limit);
    int c = 0;
    while (rises_a < n && c < limit) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_rises_reached"}, 32'(rises_a >= n), 32'd1);
  endtask

  task automatic wait_valid_a(input string tag, input int limit);
    int c = 0;
    while (!valid_a && c < limit) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_valid_seen"}, 32'(valid_a), 32'd1);
  endtask

  task automatic check_reset_outputs_a(input string tag);
    check({tag, "_busy"},       32'(busy_a),    32'd0);
    check({tag, "_done"},       32'(done_a),    32'd0);
    check({tag, "_data_clock"}, 32'(dclk_a),    32'd0);
    check({tag, "_shiftin"},    32'(shiftin_a), 32'd0);
    check({tag, "_reset_n"},    32'(reset_n_a), 32'd0);
    check({tag, "_word_data"},  data_a,         32'd0);
    check({tag, "_word_index"}, 32'(index_a),   32'd0);
    check({tag, "_word_valid"}, 32'(valid_a),   32'd0);
  endtask

  initial begin
    int cyc;
    logic clock_seen;
    logic data_moved;

    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ready_a = 1'b1; ready_b = 1'b1;
    latch_near = 32'hDEADBEEF; latch_far = 32'h12345678; latch_b = 32'h00000001;
    #2;
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);
    $display("[TB] reset values");
    check_reset_outputs_a("rst");
    check("rst_b_reset_n", 32'(reset_n_b), 32'd0);
    tick(3);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);
    check("rst_release_reset_n", 32'(reset_n_a), 32'd1);
    tick(2);

    $display("[TB] test 1: full read of two timers");
    clear_a();
    pulse_start_a();
    check("t1_busy", 32'(busy_a), 32'd1);
    wait_done_a("t1", 3000, cyc);
    check("t1_duration", 32'(cyc), 32'd1023);
    check("t1_nwords", 32'(nwords_a), 32'd2);
    check("t1_word0", words_a[0], 32'hDEADBEEF);
    check("t1_idx0", 32'(idxs_a[0]), 32'd0);
    check("t1_word1", words_a[1], 32'h12345678);
    check("t1_idx1", 32'(idxs_a[1]), 32'd1);
    check("t1_rises", 32'(rises_a), 32'd63);
    check("t1_rearm_low", 32'(rearm_low_a), 32'd4);
    check("t1_busy_at_done", 32'(busy_a), 32'd0);
    tick(5);
    check("t1_dones", 32'(dones_a), 32'd1);
    check("t1_idle_busy", 32'(busy_a), 32'd0);

    $display("[TB] test 2: host stall on first word");
    clear_a();
    ready_a = 1'b0;
    pulse_start_a();
    wait_valid_a("t2", 2000);
    check("t2_rises_at_word0", 32'(rises_a), 32'd31);
    clock_seen = 1'b0;
    data_moved = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dclk_a) clock_seen = 1'b1;
      if (data_a !== 32'hDEADBEEF || !valid_a) data_moved = 1'b1;
    end
    check("t2_stall_clock_low", 32'(clock_seen), 32'd0);
    check("t2_stall_data_held", 32'(data_moved), 32'd0);
    check("t2_stall_index", 32'(index_a), 32'd0);
    check("t2_stall_rises", 32'(rises_a), 32'd31);
    ready_a = 1'b1;
    wait_done_a("t2", 3000, cyc);
    check("t2_nwords", 32'(nwords_a), 32'd2);
    check("t2_word0", words_a[0], 32'hDEADBEEF);
    check("t2_word1", words_a[1], 32'h12345678);
    check("t2_idx1", 32'(idxs_a[1]), 32'd1);
    tick(3);

    $display("[TB] test 3: start while busy and on done");
    clear_a();
    pulse_start_a();
    wait_rises_a("t3", 20, 1000);
    pulse_start_a();
    wait_done_a("t3", 3000, cyc);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    tick(3);
    check("t3_busy_after", 32'(busy_a), 32'd0);
    check("t3_nwords", 32'(nwords_a), 32'd2);
    check("t3_dones", 32'(dones_a), 32'd1);
    check("t3_rises", 32'(rises_a), 32'd63);

    $display("[TB] test 4: reset mid-transfer");
    latch_near = 32'hCAFEF00D;
    latch_far  = 32'h0BADC0DE;
    clear_a();
    pulse_start_a();
    wait_rises_a("t4", 20, 1000);
    rst_a = 1'b1;
    #1;
    check_reset_outputs_a("t4_abort");
    @(negedge clk);
    tick(3);
    rst_a = 1'b0;
    tick(2);
    clear_a();
    pulse_start_a();
    wait_done_a("t4", 3000, cyc);
    check("t4_nwords", 32'(nwords_a), 32'd2);
    check("t4_word0", words_a[0], 32'hCAFEF00D);
    check("t4_word1", words_a[1], 32'h0BADC0DE);
    tick(3);

    $display("[TB] test 6: noise on shiftout during high phases");
    noise_en = 1'b1;
    clear_a();
    pulse_start_a();
    wait_done_a("t6", 3000, cyc);
    noise_en = 1'b0;
    check("t6_nwords", 32'(nwords_a), 32'd2);
    check("t6_word0", words_a[0], 32'hCAFEF00D);
    check("t6_word1", words_a[1], 32'h0BADC0DE);
    check("t6_rises", 32'(rises_a), 32'd63);
    tick(3);

    $display("[TB] test 5: single timer, edge bits");
    clear_b();
    pulse_start_b();
    latch_b = 32'h80000000;
    wait_done_b("t5a", 2000, cyc);
    check("t5a_duration", 32'(cyc), 32'd384);
    check("t5a_nwords", 32'(nwords_b), 32'd1);
    check("t5a_word", words_b[0], 32'h00000001);
    check("t5a_idx", 32'(idxs_b[0]), 32'd0);
    check("t5a_rises", 32'(rises_b), 32'd31);
    tick(3);
    clear_b();
    pulse_start_b();
    wait_done_b("t5b", 2000, cyc);
    check("t5b_nwords", 32'(nwords_b), 32'd1);
    check("t5b_word", words_b[0], 32'h80000000);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
